// File: rtl/mem_indirect_sequencer_pkg.sv
// mem_indirect_sequencer_pkg
// Shared definitions for the memory-indirect instruction sequencer.
// The op-code values are also used by the hazard unit that freezes the
// pipeline, so both sides decode LWi/SWi/Add identically.
//   DW_DEFAULT        default data/address width
//   MAX_WAIT_DEFAULT  default per-access timeout (MEM_SEQ_TIMEOUT_EN builds)
//   OP_*              2-bit op codes
//   seq_state_e       sequencer state encoding
package mem_indirect_sequencer_pkg;

  localparam int DW_DEFAULT       = 32;
  localparam int MAX_WAIT_DEFAULT = 15;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SWI  = 2'd1;
  localparam logic [1:0] OP_LWI  = 2'd2;
  localparam logic [1:0] OP_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PTR_RD  = 3'd1,
    ST_DATA_RD = 3'd2,
    ST_DATA_WR = 3'd3,
    ST_FIN     = 3'd4
  } seq_state_e;

  // States in which a memory strobe is outstanding.
  function automatic logic is_access_state(input seq_state_e s);
    return (s == ST_PTR_RD) || (s == ST_DATA_RD) || (s == ST_DATA_WR);
  endfunction

endpackage

// File: rtl/mem_indirect_sequencer_if.sv
// mem_indirect_sequencer_if
// Bundles the instruction request/response signals and the data-memory
// port of the sequencer.
//   op_code/op_start/base_addr/reg_data  request from EX/MEM
//   busy/done/result/error               status back to the pipeline
//   mem_addr/mem_rd/mem_wr/mem_wdata     memory port driven by the sequencer
//   mem_rdata/mem_ready                  memory response
// modport master: the sequencer (drives the memory port and status).
// modport slave:  the environment (pipeline + memory).
interface mem_indirect_sequencer_if
  import mem_indirect_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) ();

  logic [1:0]    op_code;
  logic          op_start;
  logic [DW-1:0] base_addr;
  logic [DW-1:0] reg_data;

  logic [DW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          error;

  modport master (
    input  op_code, op_start, base_addr, reg_data, mem_rdata, mem_ready,
    output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, result, error
  );

  modport slave (
    output op_code, op_start, base_addr, reg_data, mem_rdata, mem_ready,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, result, error
  );

endinterface

// File: rtl/mem_indirect_sequencer.sv
// mem_indirect_sequencer
// Runs the multi-cycle memory-indirect instructions (LWi, SWi, memory Add)
// while the pipeline is frozen, sequencing the data-memory port through
// ready-handshaked accesses and pulsing done with the result at the end.
// Ports:
//   clk   rising-edge clock
//   rest  synchronous active-high reset
//   bus   mem_indirect_sequencer_if.master (request, memory port, status)
// Parameters: DW (data/address width), MAX_WAIT (per-access timeout).
// Optional feature: define MEM_SEQ_TIMEOUT_EN to abort an access that sees
// no mem_ready within MAX_WAIT cycles (error=1, done still pulses).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for op_start with a valid op code
// ST_PTR_RD  | reading the pointer word at base_addr (LWi/SWi)
// ST_DATA_RD | reading the data word (LWi at ptr, Add at base_addr)
// ST_DATA_WR | writing reg_data (SWi at ptr) or the sum (Add at base_addr)
// ST_FIN     | one-cycle done pulse, then back to idle
module mem_indirect_sequencer
  import mem_indirect_sequencer_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rest,
  mem_indirect_sequencer_if.master bus
);

  if (MAX_WAIT < 1) begin : g_max_wait_chk
    $error("mem_indirect_sequencer: MAX_WAIT must be at least 1");
  end

  seq_state_e    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [DW-1:0] sum;
  logic          timeout_hit;

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int              WAIT_CW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_CW-1:0] WAIT_LOAD = WAIT_CW'(MAX_WAIT - 1);

  logic [WAIT_CW-1:0] wait_cnt_q, wait_cnt_d;

  // Every new strobe coincides with a state change, so reloading on a
  // state change restarts the count for each access.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = WAIT_LOAD;
    end else if (wait_cnt_q != '0) begin
      wait_cnt_d = wait_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout_hit = is_access_state(state_q) && !bus.mem_ready && (wait_cnt_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  // Add result wraps at DW bits; the carry is intentionally dropped.
  assign sum = bus.mem_rdata + data_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    result_d    = result_q;
    error_d     = error_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.op_start && (bus.op_code != OP_NONE)) begin
          op_d       = bus.op_code;
          data_d     = bus.reg_data;
          error_d    = 1'b0;
          mem_addr_d = bus.base_addr;
          mem_rd_d   = 1'b1;
          state_d    = (bus.op_code == OP_ADD) ? ST_DATA_RD : ST_PTR_RD;
        end
      end

      ST_PTR_RD: begin
        if (bus.mem_ready) begin
          mem_addr_d = bus.mem_rdata;
          if (op_q == OP_LWI) begin
            mem_rd_d = 1'b1;
            state_d  = ST_DATA_RD;
          end else begin
            mem_rd_d    = 1'b0;
            mem_wr_d    = 1'b1;
            mem_wdata_d = data_q;
            state_d     = ST_DATA_WR;
          end
        end
      end

      ST_DATA_RD: begin
        if (bus.mem_ready) begin
          mem_rd_d = 1'b0;
          if (op_q == OP_ADD) begin
            mem_wr_d    = 1'b1;
            mem_wdata_d = sum;
            result_d    = sum;
            state_d     = ST_DATA_WR;
          end else begin
            result_d = bus.mem_rdata;
            state_d  = ST_FIN;
          end
        end
      end

      ST_DATA_WR: begin
        if (bus.mem_ready) begin
          mem_wr_d = 1'b0;
          state_d  = ST_FIN;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // An abort never touches result; only the strobes and the flag change.
    if (timeout_hit) begin
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      error_d  = 1'b1;
      state_d  = ST_FIN;
    end

    busy_d = is_access_state(state_d);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      data_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
`ifdef MEM_SEQ_TIMEOUT_EN
  assign bus.error     = error_q;
`else
  assign bus.error     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_indirect_sequencer.sv
// tb_mem_indirect_sequencer
// Directed bench for mem_indirect_sequencer: a small memory model with a
// configurable number of wait states answers the memory port; each step
// drives one instruction and compares against hand-computed values.
// The timeout step is only built when MEM_SEQ_TIMEOUT_EN is defined.
module tb_mem_indirect_sequencer;
  import mem_indirect_sequencer_pkg::*;

  logic clk;
  logic rest;

  mem_indirect_sequencer_if #(.DW(32)) bus_if ();

  mem_indirect_sequencer #(.DW(32), .MAX_WAIT(15)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: contents written only by the stimulus; writes are logged.
  logic [31:0] mem [256];
  int          ws;
  bit          no_ready;
  int          rsp_cnt;
  logic [31:0] rd_log [$];
  logic [31:0] wr_alog [$];
  logic [31:0] wr_dlog [$];
  int          wr_cycles;

  assign bus_if.mem_ready = (bus_if.mem_rd || bus_if.mem_wr) && !no_ready && (rsp_cnt >= ws);
  assign bus_if.mem_rdata = mem[bus_if.mem_addr[7:0]];

  initial begin
    rsp_cnt   = 0;
    wr_cycles = 0;
  end

  always @(posedge clk) begin
    if (!(bus_if.mem_rd || bus_if.mem_wr) || bus_if.mem_ready) rsp_cnt <= 0;
    else rsp_cnt <= rsp_cnt + 1;
    if (bus_if.mem_wr) wr_cycles <= wr_cycles + 1;
    if (bus_if.mem_ready && bus_if.mem_rd) rd_log.push_back(bus_if.mem_addr);
    if (bus_if.mem_ready && bus_if.mem_wr) begin
      wr_alog.push_back(bus_if.mem_addr);
      wr_dlog.push_back(bus_if.mem_wdata);
    end
  end

  // Strobe/address stability and rd/wr exclusivity monitor.
  int          stab_viol = 0;
  logic        p_rd, p_wr, p_rdy;
  logic [31:0] p_addr, p_wdata;
  initial begin
    p_rd = 1'b0; p_wr = 1'b0; p_rdy = 1'b0; p_addr = '0; p_wdata = '0;
  end
  always @(negedge clk) begin
    if (bus_if.mem_rd && bus_if.mem_wr) stab_viol = stab_viol + 1;
    if ((p_rd || p_wr) && !p_rdy && !rest && (bus_if.mem_rd || bus_if.mem_wr)) begin
      if (bus_if.mem_rd !== p_rd || bus_if.mem_wr !== p_wr ||
          bus_if.mem_addr !== p_addr || (p_wr && bus_if.mem_wdata !== p_wdata))
        stab_viol = stab_viol + 1;
    end
    p_rd    = bus_if.mem_rd;
    p_wr    = bus_if.mem_wr;
    p_rdy   = bus_if.mem_ready;
    p_addr  = bus_if.mem_addr;
    p_wdata = bus_if.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one instruction from a negedge; returns cycles from the start
  // cycle to the done cycle (-1 if done never came within budget).
  task automatic do_op(input logic [1:0] op, input logic [31:0] base, input logic [31:0] data,
                       input int budget, input bit pulse_busy,
                       output int lat, output logic busy_first);
    int start_cyc;
    bus_if.op_code   = op;
    bus_if.base_addr = base;
    bus_if.reg_data  = data;
    bus_if.op_start  = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    bus_if.op_start = 1'b0;
    busy_first = bus_if.busy;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus_if.done) begin
        lat = cyc - start_cyc;
        break;
      end
      if (pulse_busy && bus_if.busy) begin
        bus_if.op_start  = i[0];
        bus_if.op_code   = OP_SWI;
        bus_if.base_addr = 32'h99;
        bus_if.reg_data  = 32'h5555;
      end
      @(negedge clk);
    end
    bus_if.op_start = 1'b0;
    bus_if.op_code  = OP_NONE;
  endtask

  int   lat;
  logic bf;
  int   rd0, wr0, wc0;
  bit   saw_done;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'h40;
    mem[8'h40] = 32'hDEAD;
    mem[8'h20] = 32'h80;
    mem[8'h30] = 32'hFFFF_FFFF;
    ws = 0;
    no_ready = 1'b0;
    bus_if.op_code   = OP_NONE;
    bus_if.op_start  = 1'b0;
    bus_if.base_addr = '0;
    bus_if.reg_data  = '0;
    rest = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_mem_addr",  bus_if.mem_addr, 32'h0);
    check("rst_mem_rd",    32'(bus_if.mem_rd), 32'h0);
    check("rst_mem_wr",    32'(bus_if.mem_wr), 32'h0);
    check("rst_mem_wdata", bus_if.mem_wdata, 32'h0);
    check("rst_busy",      32'(bus_if.busy), 32'h0);
    check("rst_done",      32'(bus_if.done), 32'h0);
    check("rst_result",    bus_if.result, 32'h0);
    check("rst_error",     32'(bus_if.error), 32'h0);
    rest = 1'b0;
    @(negedge clk);

    // op_code==3 with op_start is not an operation
    bus_if.op_code = OP_NONE; bus_if.op_start = 1'b1;
    @(negedge clk);
    bus_if.op_start = 1'b0;
    check("none_busy", 32'(bus_if.busy), 32'h0);
    check("none_rd",   32'(bus_if.mem_rd), 32'h0);

    // LWi, zero wait states
    rd0 = rd_log.size(); wr0 = wr_alog.size();
    do_op(OP_LWI, 32'h10, 32'h0, 20, 1'b0, lat, bf);
    check("lwi_busy_after_start", 32'(bf), 32'h1);
    check("lwi_latency", 32'(lat), 32'd3);
    check("lwi_result",  bus_if.result, 32'hDEAD);
    check("lwi_busy_at_done", 32'(bus_if.busy), 32'h0);
    check("lwi_nreads",  32'(rd_log.size() - rd0), 32'd2);
    if (rd_log.size() - rd0 == 2) begin
      check("lwi_rd0_addr", rd_log[rd0], 32'h10);
      check("lwi_rd1_addr", rd_log[rd0 + 1], 32'h40);
    end
    check("lwi_nwrites", 32'(wr_alog.size() - wr0), 32'd0);
    // start requested during FIN must be ignored
    bus_if.op_code = OP_LWI; bus_if.base_addr = 32'h10; bus_if.op_start = 1'b1;
    @(negedge clk);
    bus_if.op_start = 1'b0; bus_if.op_code = OP_NONE;
    check("fin_done_one_cycle", 32'(bus_if.done), 32'h0);
    @(negedge clk);
    check("fin_start_ignored", 32'(bus_if.busy), 32'h0);

    // SWi: mem[0x20]=0x80, store 0x1234 to 0x80
    rd0 = rd_log.size(); wr0 = wr_alog.size(); wc0 = wr_cycles;
    do_op(OP_SWI, 32'h20, 32'h1234, 20, 1'b0, lat, bf);
    check("swi_latency", 32'(lat), 32'd3);
    check("swi_result_held", bus_if.result, 32'hDEAD);
    check("swi_wr_cycles", 32'(wr_cycles - wc0), 32'd1);
    check("swi_nwrites", 32'(wr_alog.size() - wr0), 32'd1);
    if (wr_alog.size() - wr0 == 1) begin
      check("swi_wr_addr", wr_alog[wr0], 32'h80);
      check("swi_wr_data", wr_dlog[wr0], 32'h1234);
    end
    if (rd_log.size() - rd0 >= 1) check("swi_ptr_addr", rd_log[rd0], 32'h20);
    @(negedge clk);

    // Add: 0xFFFFFFFF + 2 wraps to 1
    rd0 = rd_log.size(); wr0 = wr_alog.size();
    do_op(OP_ADD, 32'h30, 32'h2, 20, 1'b0, lat, bf);
    check("add_latency", 32'(lat), 32'd3);
    check("add_result",  bus_if.result, 32'h1);
    check("add_nwrites", 32'(wr_alog.size() - wr0), 32'd1);
    if (wr_alog.size() - wr0 == 1) begin
      check("add_wr_addr", wr_alog[wr0], 32'h30);
      check("add_wr_data", wr_dlog[wr0], 32'h1);
    end
    if (rd_log.size() - rd0 >= 1) check("add_rd_addr", rd_log[rd0], 32'h30);
    @(negedge clk);

    // LWi with three wait states per access and op_start pulses while busy
    ws = 3;
    stab_viol = 0;
    rd0 = rd_log.size(); wr0 = wr_alog.size();
    do_op(OP_LWI, 32'h10, 32'h0, 40, 1'b1, lat, bf);
    check("lwi_ws_latency", 32'(lat), 32'd9);
    check("lwi_ws_result",  bus_if.result, 32'hDEAD);
    check("lwi_ws_stable",  32'(stab_viol), 32'd0);
    check("lwi_ws_nreads",  32'(rd_log.size() - rd0), 32'd2);
    if (rd_log.size() - rd0 == 2) begin
      check("lwi_ws_rd0", rd_log[rd0], 32'h10);
      check("lwi_ws_rd1", rd_log[rd0 + 1], 32'h40);
    end
    check("lwi_ws_nwrites", 32'(wr_alog.size() - wr0), 32'd0);
    @(negedge clk);
    check("lwi_ws_pulses_ignored", 32'(bus_if.busy), 32'h0);

    // Reset during DATA_WR of a SWi
    wr0 = wr_alog.size();
    bus_if.op_code = OP_SWI; bus_if.base_addr = 32'h20; bus_if.reg_data = 32'hABCD;
    bus_if.op_start = 1'b1;
    @(negedge clk);
    bus_if.op_start = 1'b0; bus_if.op_code = OP_NONE;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.mem_wr) break;
      @(negedge clk);
    end
    check("rstwr_reached_wr", 32'(bus_if.mem_wr), 32'h1);
    rest = 1'b1;
    @(negedge clk);
    check("rstwr_mem_wr", 32'(bus_if.mem_wr), 32'h0);
    check("rstwr_busy",   32'(bus_if.busy), 32'h0);
    check("rstwr_done",   32'(bus_if.done), 32'h0);
    check("rstwr_result", bus_if.result, 32'h0);
    rest = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.done) saw_done = 1'b1;
    end
    check("rstwr_no_done", 32'(saw_done), 32'h0);
    check("rstwr_no_write", 32'(wr_alog.size() - wr0), 32'd0);

    // Sequencer is back in IDLE: a fresh LWi behaves normally
    ws = 0;
    do_op(OP_LWI, 32'h10, 32'h0, 20, 1'b0, lat, bf);
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_result",  bus_if.result, 32'hDEAD);
    check("no_rd_wr_overlap", 32'(stab_viol), 32'd0);
    check("error_stays_low",  32'(bus_if.error), 32'h0);
    @(negedge clk);

`ifdef MEM_SEQ_TIMEOUT_EN
    // No mem_ready ever: 15 strobe cycles, then abort through FIN
    no_ready = 1'b1;
    do_op(OP_LWI, 32'h10, 32'h0, 40, 1'b0, lat, bf);
    check("to_latency", 32'(lat), 32'd16);
    check("to_error",   32'(bus_if.error), 32'h1);
    check("to_result_held", bus_if.result, 32'hDEAD);
    check("to_strobe_dropped", 32'(bus_if.mem_rd), 32'h0);
    no_ready = 1'b0;
    @(negedge clk);
    do_op(OP_ADD, 32'h30, 32'h5, 20, 1'b0, lat, bf);
    check("to_clear_latency", 32'(lat), 32'd3);
    check("to_error_cleared", 32'(bus_if.error), 32'h0);
    check("to_add_result", bus_if.result, 32'h4);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
